// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Streams a program into the instruction memory over a valid/ready word
// interface and holds the core in reset until BOOT_DELAY cycles after the
// last accepted word.
// Optional feature macro: IMEM_BOOT_LOADER_CHECKSUM_EN -- adds a CHECK state
// that takes one trailing checksum word. The core is only released when the
// program words plus the checksum sum to zero.
module imem_boot_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int BOOT_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  imem_web,
    output logic [ADDR_WIDTH-1:0] imem_addr_input,
    output logic                  core_resetn,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int                  CNT_W      = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [CNT_W-1:0]    DELAY_INIT = CNT_W'(BOOT_DELAY - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LEN  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LEN_ONE    = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DELAY,
        RUN,
        ERR
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [CNT_W-1:0]      delay_cnt;
    logic                  accept;
    logic                  len_ok;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
`endif

    // Ready is purely a function of state so the source can see it before the edge
    always_comb begin
        in_ready = (state == LOAD);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        if (state == CHECK) begin
            in_ready = 1'b1;
        end
`endif
    end

    assign accept = in_valid && in_ready;
    assign len_ok = (load_len != '0) && (load_len <= DEPTH_LEN);

    // Load sequencer: state, counters and all registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            imem_web        <= 1'b1;
            imem_wdata      <= '0;
            imem_addr_input <= '0;
            core_resetn     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            addr            <= '0;
            remaining       <= '0;
            delay_cnt       <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            sum             <= '0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse; data/address hold otherwise
            imem_web <= 1'b1;
            case (state)
                IDLE, RUN, ERR: begin
                    if (start) begin
                        core_resetn <= 1'b0;
                        done        <= 1'b0;
                        if (len_ok) begin
                            state     <= LOAD;
                            addr      <= '0;
                            remaining <= load_len;
                            error     <= 1'b0;
                            busy      <= 1'b1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                            sum       <= '0;
`endif
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        imem_web        <= 1'b0;
                        imem_wdata      <= in_data;
                        imem_addr_input <= addr;
                        addr            <= addr + 1'b1;
                        remaining       <= remaining - 1'b1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                        sum             <= sum + in_data;
                        if (remaining == LEN_ONE) begin
                            state <= CHECK;
                        end
`else
                        if (remaining == LEN_ONE) begin
                            state     <= DELAY;
                            delay_cnt <= DELAY_INIT;
                        end
`endif
                    end
                end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if ((sum + in_data) == '0) begin
                            state     <= DELAY;
                            delay_cnt <= DELAY_INIT;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
`endif
                DELAY: begin
                    if (delay_cnt == '0) begin
                        state       <= RUN;
                        core_resetn <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Streams a program into the single-port instruction memory through a valid/ready word interface.
- Drives the memory write port: imem_wdata, active-low imem_web, imem_addr_input.
- Holds the core in reset (core_resetn) while loading. Releases it a programmable delay after the last write.
- Replaces hand-sequenced testbench/host writes. Supports reload from RUN and parametrised width and depth.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 5, imem word-address width.
- RAM_DEPTH, 1 << ADDR_WIDTH, imem depth in words. Must be at most 2^ADDR_WIDTH.
- BOOT_DELAY, 4, cycles from the last accepted word to core release. Minimum 1.

Ports:
- clk, input, 1, single clock. All logic on the rising edge.
- resetn, input, 1, reset. Asynchronous, active-low.
- start, input, 1, one-cycle request to begin a load.
- load_len, input, ADDR_WIDTH+1, number of words to load. Sampled on start.
- in_data, input, DATA_WIDTH, program word.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, loader accepts a word this cycle.
- imem_wdata, output, DATA_WIDTH, imem write data.
- imem_web, output, 1, imem write enable, active-low.
- imem_addr_input, output, ADDR_WIDTH, imem write address.
- core_resetn, output, 1, core reset, active-low.
- busy, output, 1, state is LOAD, CHECK or DELAY.
- done, output, 1, program loaded and core running.
- error, output, 1, last load request rejected or failed.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE.
  - imem_web=1, imem_wdata=0, imem_addr_input=0.
  - core_resetn=0, busy=0, done=0, error=0.
  - Internal word counter and delay counter cleared.
- States are IDLE, LOAD, CHECK (optional feature only), DELAY, RUN, ERR.
- in_ready is combinational: in_ready=(state==LOAD or state==CHECK). No other path drives it.
- IDLE / ERR / RUN on start=1:
  - If 1 <= load_len <= RAM_DEPTH: go to LOAD. Word address=0, remaining=load_len. Clear error and done. core_resetn drops to 0 at the same edge.
  - Otherwise: go to ERR, error=1, core_resetn=0.
- start is ignored in LOAD, CHECK and DELAY.
- LOAD:
  - A word is accepted on an edge where in_valid and in_ready are both 1.
  - Registered write: in the cycle after acceptance, imem_web=0, imem_wdata=accepted word, imem_addr_input=address of that word. imem_web is low for exactly one cycle per word.
  - imem_addr_input and imem_wdata hold their last values while imem_web=1.
  - The word address increments by 1 per accept.
  - in_valid gaps insert idle cycles with imem_web=1. There is no timeout.
  - On the accept of word load_len: go to DELAY (or CHECK if the feature is enabled). in_ready is 0 from the next cycle.
- DELAY:
  - The delay counter is loaded with BOOT_DELAY-1 at the last accept and decrements each cycle.
  - At 0, go to RUN. core_resetn rises at the BOOT_DELAY-th rising edge after the edge that accepted the last word.
- RUN: core_resetn=1, done=1. Both hold until the next start or resetn.
- Addressing: load_len=RAM_DEPTH writes addresses 0..RAM_DEPTH-1. No wrap-around ever occurs.
- Reset mid-load: all outputs return to reset values immediately. Words already written stay in imem. A fresh start is required.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CHECKSUM_EN.
- When defined:
  - After word load_len, the loader enters CHECK and accepts exactly one extra word (the checksum). The checksum is not written: imem_web stays 1.
  - Sum of all load_len words plus the checksum, mod 2^DATA_WIDTH, equal to 0: go to DELAY. The DELAY counter starts from the checksum accept edge.
  - Any other sum: go to ERR, error=1, core_resetn stays 0.
- When undefined: no CHECK state. LOAD goes directly to DELAY.

Test Plan:
- load_len=3 with words 0x00500113, 0x00C00193, 0xFF718393, in_valid held high:
  - imem_web low for 3 consecutive cycles at addresses 0, 1, 2 with matching data.
  - core_resetn rises 4 edges after the third accept; done=1.
- Same 3 words with in_valid low for 2 cycles between words:
  - Writes are delayed accordingly, with no duplicate or missing imem_web pulses.
  - Addresses remain 0, 1, 2.
- load_len=0, then load_len=33 (ADDR_WIDTH=5):
  - Each gives error=1, core_resetn=0 and no imem_web pulse.
  - A following start with load_len=1 clears error.
- resetn pulsed low after 2 of 5 words accepted:
  - imem_web=1, core_resetn=0, busy=0 asynchronously.
  - in_ready=0 until a new start.
- From RUN, start with load_len=2:
  - core_resetn=0 at the start edge; done=0.
  - Words are written at addresses 0 and 1, and core_resetn is re-released.
- With IMEM_BOOT_LOADER_CHECKSUM_EN, words 0x00000001, 0x00000002:
  - Checksum 0xFFFFFFFD gives RUN.
  - Checksum 0x00000000 gives ERR with core_resetn held at 0.
